// File: rtl/br_redirect_ctrl.sv
// Branch redirect sequencer: registers PC redirect requests from EX,
// squashes wrong-path stages, freezes fetch on halt, counts branches.
module br_redirect_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_br,
  input  logic [1:0]        PCSrc,
  input  logic              stall,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] alu_target,
  input  logic              pc_ready,
  input  logic              resume,
  input  logic              cnt_clr,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              pc_hold,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;

  logic acc;
  logic sel_rel;
  logic sel_reg;
  logic sel_halt;
  logic taken;

  assign acc      = ex_valid & ~stall & (state == RUN);
  assign sel_rel  = acc & (PCSrc == 2'b01);
  assign sel_reg  = acc & (PCSrc == 2'b10);
  assign sel_halt = acc & (PCSrc == 2'b11);
  assign taken    = sel_rel | sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      pc_hold        <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          unique case (1'b1)
            sel_rel: begin
              state          <= REDIR;
              redirect_pc    <= br_target;
              redirect_valid <= 1'b1;
              flush_ifid     <= 1'b1;
              flush_idex     <= 1'b1;
            end
            sel_reg: begin
              state          <= REDIR;
              redirect_pc    <= alu_target;
              redirect_valid <= 1'b1;
              flush_ifid     <= 1'b1;
              flush_idex     <= 1'b1;
            end
            sel_halt: begin
              state      <= HALT;
              pc_hold    <= 1'b1;
              flush_ifid <= 1'b1;
            end
            default: begin
              state          <= RUN;
              redirect_valid <= 1'b0;
              flush_ifid     <= 1'b0;
              flush_idex     <= 1'b0;
              pc_hold        <= 1'b0;
            end
          endcase
        end
        REDIR: begin
          if (pc_ready) begin
            state          <= RUN;
            redirect_valid <= 1'b0;
            flush_ifid     <= 1'b0;
            flush_idex     <= 1'b0;
          end
        end
        HALT: begin
          if (resume) begin
            state      <= RUN;
            pc_hold    <= 1'b0;
            flush_ifid <= 1'b0;
          end
        end
        default: begin
          state          <= RUN;
          redirect_valid <= 1'b0;
          flush_ifid     <= 1'b0;
          flush_idex     <= 1'b0;
          pc_hold        <= 1'b0;
        end
      endcase
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (acc && ex_is_br && (br_cnt != '1))
        br_cnt <= br_cnt + 1'b1;
      if (taken && (taken_cnt != '1))
        taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed bench for br_redirect_ctrl with narrow counters
// so saturation is reachable.
module tb_br_redirect_ctrl;

  localparam int AW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_is_br;
  logic [1:0]    PCSrc;
  logic          stall;
  logic [AW-1:0] br_target;
  logic [AW-1:0] alu_target;
  logic          pc_ready;
  logic          resume;
  logic          cnt_clr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          flush_ifid;
  logic          flush_idex;
  logic          pc_hold;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  br_redirect_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_is_br(ex_is_br),
    .PCSrc(PCSrc),
    .stall(stall),
    .br_target(br_target),
    .alu_target(alu_target),
    .pc_ready(pc_ready),
    .resume(resume),
    .cnt_clr(cnt_clr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .pc_hold(pc_hold),
    .br_cnt(br_cnt),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {redirect_valid, flush_ifid, flush_idex, pc_hold}
  task automatic chk_out(input string tag, input logic [3:0] fl,
                         input logic [CW-1:0] b, input logic [CW-1:0] t);
    chk({tag, ".flags"},
        {60'd0, redirect_valid, flush_ifid, flush_idex, pc_hold},
        {60'd0, fl});
    chk({tag, ".br"}, {60'd0, br_cnt}, {60'd0, b});
    chk({tag, ".taken"}, {60'd0, taken_cnt}, {60'd0, t});
  endtask

  task automatic idle();
    ex_valid = 0;
    ex_is_br = 0;
    PCSrc    = 2'b00;
    stall    = 0;
    pc_ready = 0;
    resume   = 0;
    cnt_clr  = 0;
  endtask

  task automatic issue(input logic [1:0] src, input logic isbr);
    ex_valid = 1;
    ex_is_br = isbr;
    PCSrc    = src;
  endtask

  initial begin
    idle();
    br_target  = '0;
    alu_target = '0;
    rst_n = 0;
    tick();
    tick();
    chk_out("reset", 4'b0000, 0, 0);
    chk("reset.pc", redirect_pc, 64'h0);
    rst_n = 1;
    tick();

    // Non-branch sequential instruction: nothing happens
    issue(2'b00, 1'b0);
    tick();
    idle();
    chk_out("seq", 4'b0000, 0, 0);

    // PC-relative redirect held until accepted
    br_target = 64'h400;
    issue(2'b01, 1'b1);
    tick();
    idle();
    br_target = 64'h999;
    chk_out("rel", 4'b1110, 1, 1);
    chk("rel.pc", redirect_pc, 64'h400);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rel.hold", 4'b1110, 1, 1);
      chk("rel.hold.pc", redirect_pc, 64'h400);
    end
    pc_ready = 1;
    tick();
    pc_ready = 0;
    chk_out("rel.acc", 4'b0000, 1, 1);

    // Async reset in the middle of a redirect
    br_target = 64'h800;
    issue(2'b01, 1'b1);
    tick();
    idle();
    chk_out("pre_rst", 4'b1110, 2, 2);
    rst_n = 0;
    #1;
    chk_out("async_rst", 4'b0000, 0, 0);
    chk("async_rst.pc", redirect_pc, 64'h0);
    tick();
    rst_n = 1;
    tick();
    chk_out("post_rst", 4'b0000, 0, 0);

    // Stalled register-target branch is accepted exactly once
    alu_target = 64'h1000;
    issue(2'b10, 1'b1);
    stall = 1;
    tick();
    chk_out("stall1", 4'b0000, 0, 0);
    tick();
    chk_out("stall2", 4'b0000, 0, 0);
    stall = 0;
    tick();
    idle();
    chk_out("unstall", 4'b1110, 1, 1);
    chk("unstall.pc", redirect_pc, 64'h1000);
    pc_ready = 1;
    tick();
    pc_ready = 0;
    chk_out("unstall.acc", 4'b0000, 1, 1);

    // Wrong-path instruction arriving with pc_ready is squashed
    br_target = 64'h2000;
    issue(2'b01, 1'b1);
    tick();
    chk_out("sq.redir", 4'b1110, 2, 2);
    br_target = 64'h3000;
    pc_ready  = 1;
    tick();
    idle();
    chk_out("sq.ret", 4'b0000, 2, 2);
    tick();
    chk_out("sq.none", 4'b0000, 2, 2);
    chk("sq.pc", redirect_pc, 64'h2000);

    // Halt: fetch frozen until resume; pc_ready and EX ignored
    issue(2'b11, 1'b1);
    tick();
    idle();
    chk_out("halt", 4'b0101, 3, 2);
    pc_ready = 1;
    issue(2'b01, 1'b1);
    tick();
    tick();
    idle();
    chk_out("halt.hold", 4'b0101, 3, 2);
    resume = 1;
    tick();
    resume = 0;
    chk_out("resume", 4'b0000, 3, 2);

    // Saturation of narrow counters
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk_out("clr", 4'b0000, 0, 0);
    br_target = 64'h40;
    for (int i = 0; i < 20; i++) begin
      issue(2'b01, 1'b1);
      tick();
      idle();
      pc_ready = 1;
      tick();
      pc_ready = 0;
    end
    chk_out("sat", 4'b0000, 15, 15);

    // Clear has priority over a concurrent accepted branch
    issue(2'b01, 1'b1);
    cnt_clr = 1;
    tick();
    idle();
    chk_out("clr_pri", 4'b1110, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
